// File: rtl/heston_q824_pkg.sv
// Shared Q8.24 fixed-point definitions for the Heston volatility/variance datapath.
// Holds the word format constants and the sequential-squarer FSM state encoding.
package heston_q824_pkg;

    localparam int          Q_W    = 32;
    localparam int          Q_FRAC = 24;
    localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/square_q824_seq.sv
// Sequential Q8.24 squarer (volatility -> variance): one shift-add per clock,
// round-half-up back to Q8.24 and saturate to the largest positive value.
module square_q824_seq
    import heston_q824_pkg::*;
#(
    parameter int Q_W    = heston_q824_pkg::Q_W,
    parameter int Q_FRAC = heston_q824_pkg::Q_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_sq,
    output logic           out_ovf
);

    localparam int               P_W      = 2 * Q_W;
    localparam int               CNT_W    = $clog2(Q_W);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(Q_W - 1);
    localparam logic [P_W-1:0]   RND_HALF = P_W'(1) << (Q_FRAC - 1);
    localparam logic [P_W-1:0]   SAT_LIM  = P_W'(Q_MAX);

    sq_state_t        state_q, state_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [Q_W-1:0]   mcand_q, mcand_d;
    logic [Q_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Q_W-1:0]   sq_q, sq_d;
    logic             ovf_q, ovf_d;

    logic [Q_W-1:0]   abs_a;
    logic [P_W-1:0]   step_acc;
    logic [P_W-1:0]   rnd_p;
    logic [P_W-1:0]   res;

    // Two's-complement negate; 0x80000000 maps to 2^31 when read as unsigned.
    assign abs_a    = in_a[Q_W-1] ? (~in_a + 1'b1) : in_a;
    assign step_acc = acc_q + (mplier_q[0] ? ({{Q_W{1'b0}}, mcand_q} << cnt_q) : '0);
    assign rnd_p    = step_acc + RND_HALF;
    assign res      = rnd_p >> Q_FRAC;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sq_d     = sq_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = abs_a;
                    mplier_d = abs_a;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = step_acc;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    if (res > SAT_LIM) begin
                        sq_d  = Q_W'(Q_MAX);
                        ovf_d = 1'b1;
                    end else begin
                        sq_d  = res[Q_W-1:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sq_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sq_q     <= sq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sq    = sq_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/square_q824_seq.md
SQUARE_Q824_SEQ -- requirements
Module: square_q824_seq

Interface
REQ-001 SHALL: Q_W, default 32, total width of a signed Q8.24 word.
REQ-002 SHALL: Q_FRAC, default 24, number of fractional bits.
REQ-003 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL: in_valid  input  1  operand valid.
REQ-006 SHALL: in_ready  output  1  block can accept an operand.
REQ-007 SHALL: in_a  input  32  signed Q8.24 operand (volatility-domain value).
REQ-008 SHALL: out_valid  output  1  result valid.
REQ-009 SHALL: out_ready  input  1  consumer accepts the result.
REQ-010 SHALL: out_sq  output  32  signed Q8.24 square of in_a, always >= 0.
REQ-011 SHALL: out_ovf  output  1  result saturated; valid while out_valid is high.

Function
REQ-012 SHALL: compute in_a*in_a sequentially, one shift-add step per clock, as the inverse of the combinational Q8.24 square root (vol <-> variance).
REQ-013 SHALL: use an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL: assert in_ready only in IDLE.
REQ-015 SHALL: accept an operand when in_valid && in_ready at a rising edge -> capture |in_a| as 32-bit unsigned (0x80000000 -> 2^31), clear the 64-bit accumulator and step counter, go to CALC.
REQ-016 SHALL: in CALC, add (|a| << i) to the accumulator when multiplier bit i is 1, for i = 0..31, one bit per cycle.
REQ-017 SHALL: stay in CALC exactly 32 cycles; accept in cycle k -> CALC in cycles k+1..k+32 -> DONE with out_valid=1 in cycle k+33.
REQ-018 SHALL: form the result as R = (P + 2^23) >> 24, where P is the 64-bit unsigned product (round half up).
REQ-019 SHALL: when R > 0x7FFFFFFF, set out_sq = 0x7FFFFFFF and out_ovf = 1; otherwise set out_sq = R[31:0] and out_ovf = 0.
REQ-020 SHALL: ignore in_a after acceptance; operand changes during CALC/DONE have no effect.
REQ-021 SHALL: in DONE, hold out_valid, out_sq and out_ovf stable until out_valid && out_ready.
REQ-022 SHALL: on the output handshake, go to IDLE; the earliest next accept is the following cycle, so at most one operation is in flight.
REQ-023 SHALL: keep out_valid at 0 in IDLE and CALC.
REQ-024 SHALL: ignore out_ready outside DONE.

Reset
REQ-025 SHALL: on rst=1 at a clock edge -> state IDLE, in_ready=1 in the following cycle, out_valid=0, out_sq=0, out_ovf=0, accumulator and counter cleared.
REQ-026 SHALL: rst in CALC or DONE aborts the operation and discards the result; no out_valid pulse follows.
REQ-027 SHALL: rst has priority over simultaneous in or out handshakes.

Structure
REQ-028 SHALL: place Q_W, Q_FRAC, the Q8.24 maximum (0x7FFFFFFF) and the FSM state enum in the shared package heston_q824_pkg.
REQ-029 SHALL: be a single module with no sub-module; the 64-bit accumulator, 32-bit multiplicand, 32-bit multiplier shift register and 5-bit counter are local.

Verification
REQ-030 SHALL: in_a=0x02000000 (2.0) -> out_sq=0x04000000, out_ovf=0, out_valid first high 33 cycles after accept.
REQ-031 SHALL: in_a=0xFE800000 (-1.5) -> out_sq=0x02400000 (2.25), out_ovf=0.
REQ-032 SHALL: in_a=0x10000000 (16.0) and in_a=0x80000000 -> out_sq=0x7FFFFFFF, out_ovf=1.
REQ-033 SHALL: rounding: in_a=0x00001000 -> 0x00000001; in_a=0x00000001 -> 0x00000000.
REQ-034 SHALL: out_ready held low 10 cycles in DONE, in_valid and in_a toggling meanwhile -> out_sq stable, in_ready=0, no new accept; single result after out_ready rises.
REQ-035 SHALL: rst pulsed in the 15th CALC cycle -> out_valid never rises; in_ready=1 in the cycle after reset, and the next operand (3.0 = 0x03000000) -> 0x09000000.
